// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg
// Shared definitions for the tiny CPU datapath blocks: data width, register
// count / address width and the sequencer FSM state encoding.
package tiny_cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_CNT    = 4;
  localparam int REG_ADDR_W = $clog2(REG_CNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    LOAD  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_file_4x8.sv
// reg_file_4x8
// Small register file with two asynchronous read ports and one synchronous
// write port. All entries are cleared synchronously while reset is high.
//
// Ports:
//   clk        clock, writes on rising edge
//   reset      synchronous active-high clear of every entry
//   wr_en      write enable
//   wr_addr    write address
//   wr_data    write data
//   rd_a_addr  read port A address
//   rd_a_data  read port A data (combinational)
//   rd_b_addr  read port B address
//   rd_b_data  read port B data (combinational)
module reg_file_4x8 #(
  parameter int DATA_W  = tiny_cpu_pkg::DATA_W,
  parameter int REG_CNT = tiny_cpu_pkg::REG_CNT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(REG_CNT)-1:0] wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(REG_CNT)-1:0] rd_a_addr,
  output logic [DATA_W-1:0]          rd_a_data,
  input  logic [$clog2(REG_CNT)-1:0] rd_b_addr,
  output logic [DATA_W-1:0]          rd_b_data
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = regs[rd_a_addr];
  assign rd_b_data = regs[rd_b_addr];

endmodule

// File: rtl/nand_operand_sequencer.sv
// nand_operand_sequencer
// Feeder and writeback stage for the 8-bit NAND unit. Accepts one
// instruction at a time, either loads an immediate into the register file or
// presents two registered operands to the external NAND unit and writes the
// returned result back to the destination register.
//
// Optional feature: define TINY_CPU_ZERO_FLAG_EN to add the zero_flag output,
// which tracks whether the most recent register-file write was zero.
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   instr_valid  instruction present
//   instr_ready  high only while idle
//   instr_load   1 = load immediate, 0 = NAND rs1, rs2
//   instr_rd     destination register
//   instr_rs1    source A
//   instr_rs2    source B
//   instr_imm    immediate for loads
//   op_a, op_b   registered operands driven to the NAND unit
//   nand_result  combinational result from the NAND unit
//   wb_data      last value written to the register file
//   done         one-cycle pulse per retired instruction
//   zero_flag    (TINY_CPU_ZERO_FLAG_EN only) last written value was zero
module nand_operand_sequencer #(
  parameter int DATA_W  = tiny_cpu_pkg::DATA_W,
  parameter int REG_CNT = tiny_cpu_pkg::REG_CNT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic                       instr_load,
  input  logic [$clog2(REG_CNT)-1:0] instr_rd,
  input  logic [$clog2(REG_CNT)-1:0] instr_rs1,
  input  logic [$clog2(REG_CNT)-1:0] instr_rs2,
  input  logic [DATA_W-1:0]          instr_imm,
  output logic [DATA_W-1:0]          op_a,
  output logic [DATA_W-1:0]          op_b,
  input  logic [DATA_W-1:0]          nand_result,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       done
`ifdef TINY_CPU_ZERO_FLAG_EN
  ,
  output logic                       zero_flag
`endif
);

  import tiny_cpu_pkg::*;

  localparam int ADDR_W = $clog2(REG_CNT);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] imm_q;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_a_data, rf_b_data;

  reg_file_4x8 #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (rf_we),
    .wr_addr   (rd_q),
    .wr_data   (rf_wdata),
    .rd_a_addr (rs1_q),
    .rd_a_data (rf_a_data),
    .rd_b_addr (rs2_q),
    .rd_b_data (rf_b_data)
  );

  // Next-state and write-port control. The load/NAND choice is made once at
  // accept time and is encoded by which state follows IDLE.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = imm_q;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d = instr_load ? LOAD : FETCH;
        end
      end
      FETCH: begin
        state_d = EXEC;
      end
      EXEC: begin
        rf_we    = 1'b1;
        rf_wdata = nand_result;
        state_d  = IDLE;
      end
      LOAD: begin
        rf_we    = 1'b1;
        rf_wdata = imm_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operands are captured only in FETCH so nand_result stays stable through
  // EXEC, and so an rd that aliases rs1/rs2 still sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      wb_data <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= rf_we;
      if (state_q == IDLE && instr_valid) begin
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        imm_q <= instr_imm;
      end
      if (state_q == FETCH) begin
        op_a <= rf_a_data;
        op_b <= rf_b_data;
      end
      if (rf_we) begin
        wb_data <= rf_wdata;
      end
    end
  end

`ifdef TINY_CPU_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_flag <= 1'b0;
    end else if (rf_we) begin
      zero_flag <= (rf_wdata == '0);
    end
  end
`endif

endmodule
